// File: rtl/ht_pkg.sv
// Shared definitions for the parametrised Huffman core.
// Latency: none (types and constant functions only).
// Backpressure: n/a.
package ht_pkg;

  // Top-level sequencing: load weights, build the tree, stream the codes.
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_OUT
  } state_t;

  // Width of a symbol index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Internal node weight width. The sum of n weights each below 2**w_width
  // stays below 2**(w_width + idx_w(n)), so merging can never overflow.
  function automatic int node_w(input int w_width, input int n);
    return w_width + idx_w(n);
  endfunction

endpackage

// File: rtl/ht_min2_sel.sv
// Two-minimum finder over NUM_SYM {active, weight} tree slots.
// Latency: combinational.
// Backpressure: none.
// Ports: active/weight describe the slots; min1/min2 are the slot indices
// holding the lowest and second-lowest {weight, index} keys.
module ht_min2_sel
  import ht_pkg::*;
#(
  parameter int NUM_SYM = 8,
  parameter int NW      = 6
) (
  input  logic [NUM_SYM-1:0]         active,
  input  logic [NW-1:0]              weight [NUM_SYM],
  output logic [idx_w(NUM_SYM)-1:0]  min1,
  output logic [idx_w(NUM_SYM)-1:0]  min2
);

  localparam int IW = idx_w(NUM_SYM);

  logic          have1;
  logic          have2;
  logic [NW-1:0] w1;
  logic [NW-1:0] w2;

  // Scanning in ascending slot order with strict comparisons means an equal
  // weight never displaces an earlier slot, so ties resolve to the lower index.
  always_comb begin
    have1 = 1'b0;
    have2 = 1'b0;
    w1    = '0;
    w2    = '0;
    min1  = '0;
    min2  = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (active[i]) begin
        if (!have1 || (weight[i] < w1)) begin
          min2  = min1;
          w2    = w1;
          have2 = have1;
          min1  = IW'(i);
          w1    = weight[i];
          have1 = 1'b1;
        end else if (!have2 || (weight[i] < w2)) begin
          min2  = IW'(i);
          w2    = weight[i];
          have2 = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ht_core_param.sv
// Huffman core: serial weight load, one tree merge per cycle, bit-serial code output.
// Latency: first code bit NUM_SYM cycles after the last load cycle.
// Backpressure: none; in_valid is ignored outside IDLE/LOAD, output cannot stall.
// Ports: clk/rst (sync, active-high); in_valid/in_weight/in_sym load leaf weights
// and the output symbol sequence; out_valid/out_code stream the selected codes.
// Optional macro HT_OUT_LAST_EN adds out_last, marking each code's final bit.
module ht_core_param
  import ht_pkg::*;
#(
  parameter int NUM_SYM = 8,
  parameter int W_WIDTH = 3,
  parameter int OUT_LEN = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W_WIDTH-1:0]         in_weight,
  input  logic [idx_w(NUM_SYM)-1:0]  in_sym,
  output logic                       out_valid,
  output logic                       out_code
`ifdef HT_OUT_LAST_EN
  ,
  output logic                       out_last
`endif
);

  localparam int IW = idx_w(NUM_SYM);
  localparam int NW = node_w(W_WIDTH, NUM_SYM);
  localparam int CW = NUM_SYM - 1;

  localparam logic [IW-1:0] LAST_LEAF  = IW'(NUM_SYM - 1);
  localparam logic [IW-1:0] LAST_MERGE = IW'(NUM_SYM - 2);
  localparam logic [IW-1:0] LAST_SEQ   = IW'(OUT_LEN - 1);

  state_t state;
  state_t state_nxt;

  logic [NW-1:0]      weight [NUM_SYM];
  logic [NUM_SYM-1:0] active;
  logic [IW-1:0]      grp    [NUM_SYM];
  logic [CW-1:0]      code   [NUM_SYM];
  logic [IW-1:0]      len    [NUM_SYM];
  logic [IW-1:0]      seq    [OUT_LEN];

  logic [IW-1:0] k;     // next leaf to load
  logic [IW-1:0] mcnt;  // merges completed
  logic [IW-1:0] j;     // sequence entry being emitted
  logic [IW-1:0] pos;   // bits of the current code already emitted

  logic [IW-1:0] min1;
  logic [IW-1:0] min2;

  logic [IW-1:0] cur_sym;
  logic [IW-1:0] len_m1;
  logic [IW-1:0] bit_idx;
  logic          cur_bit;
  logic          sym_last;
  logic          valid_nxt;
  logic          code_nxt;
  logic          last_nxt;

  ht_min2_sel #(
    .NUM_SYM (NUM_SYM),
    .NW      (NW)
  ) u_min2 (
    .active (active),
    .weight (weight),
    .min1   (min1),
    .min2   (min2)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid)                      state_nxt = S_LOAD;
      S_LOAD:  if (in_valid && (k == LAST_LEAF))  state_nxt = S_MERGE;
      S_MERGE: if (mcnt == LAST_MERGE)            state_nxt = S_OUT;
      S_OUT:   if (sym_last && (j == LAST_SEQ))   state_nxt = S_IDLE;
      default:                                    state_nxt = S_IDLE;
    endcase
  end

  // Output logic: codes are stored root bit highest, so the emitted bit
  // index counts down from len-1 as pos counts up.
  always_comb begin
    cur_sym   = seq[j];
    len_m1    = len[cur_sym] - IW'(1);
    bit_idx   = len_m1 - pos;
    cur_bit   = code[cur_sym][bit_idx];
    sym_last  = (pos == len_m1);
    valid_nxt = (state == S_OUT);
    code_nxt  = valid_nxt & cur_bit;
    last_nxt  = valid_nxt & sym_last;
  end

  // Datapath: load, merge and output counters plus the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        weight[i] <= '0;
        grp[i]    <= '0;
        code[i]   <= '0;
        len[i]    <= '0;
      end
      for (int i = 0; i < OUT_LEN; i++) seq[i] <= '0;
      active    <= '0;
      k         <= '0;
      mcnt      <= '0;
      j         <= '0;
      pos       <= '0;
      out_valid <= 1'b0;
      out_code  <= 1'b0;
    end else begin
      out_valid <= valid_nxt;
      out_code  <= code_nxt;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Every new load starts from a clean forest of single leaves.
            for (int i = 0; i < NUM_SYM; i++) begin
              weight[i] <= (i == 0) ? NW'(in_weight) : '0;
              grp[i]    <= IW'(i);
              code[i]   <= '0;
              len[i]    <= '0;
            end
            active <= '1;
            seq[0] <= in_sym;
            k      <= IW'(1);
            mcnt   <= '0;
            j      <= '0;
            pos    <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            weight[k] <= NW'(in_weight);
            if (int'(k) < OUT_LEN) seq[k] <= in_sym;
            k <= k + IW'(1);
          end
        end
        S_MERGE: begin
          for (int i = 0; i < NUM_SYM; i++) begin
            if (grp[i] == min1) begin
              code[i][len[i]] <= 1'b1;
              len[i]          <= len[i] + IW'(1);
              grp[i]          <= min2;
            end else if (grp[i] == min2) begin
              code[i][len[i]] <= 1'b0;
              len[i]          <= len[i] + IW'(1);
            end
          end
          // The merged subtree lives on in slot min2.
          weight[min2] <= weight[min1] + weight[min2];
          active[min1] <= 1'b0;
          mcnt         <= mcnt + IW'(1);
          j            <= '0;
          pos          <= '0;
        end
        S_OUT: begin
          if (sym_last) begin
            pos <= '0;
            j   <= (j == LAST_SEQ) ? '0 : j + IW'(1);
          end else begin
            pos <= pos + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HT_OUT_LAST_EN
  always_ff @(posedge clk) begin
    if (rst) out_last <= 1'b0;
    else     out_last <= last_nxt;
  end
`else
  logic unused_last;
  assign unused_last = last_nxt;
`endif

endmodule

// File: tb/tb_ht_core_param.sv
// Bench for ht_core_param: a default 8-symbol instance and a 4-symbol instance
// share the clock, reset and input buses; sel picks which one is driven/observed.
module tb_ht_core_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       = 1'b1;
  logic       in_valid  = 1'b0;
  logic [3:0] in_weight = '0;
  logic [2:0] in_sym    = '0;
  bit         sel       = 1'b0;

  logic ov8, oc8, ov4, oc4;
  logic v8_in, v4_in;
  logic obs_valid, obs_code;
  assign v8_in     = in_valid & ~sel;
  assign v4_in     = in_valid & sel;
  assign obs_valid = sel ? ov4 : ov8;
  assign obs_code  = sel ? oc4 : oc8;
`ifdef HT_OUT_LAST_EN
  logic ol8, ol4, obs_last;
  assign obs_last = sel ? ol4 : ol8;
`endif

  ht_core_param #(.NUM_SYM(8), .W_WIDTH(3), .OUT_LEN(5)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8_in),
    .in_weight (in_weight[2:0]),
    .in_sym    (in_sym),
    .out_valid (ov8),
    .out_code  (oc8)
`ifdef HT_OUT_LAST_EN
    ,
    .out_last  (ol8)
`endif
  );

  ht_core_param #(.NUM_SYM(4), .W_WIDTH(4), .OUT_LEN(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v4_in),
    .in_weight (in_weight),
    .in_sym    (in_sym[1:0]),
    .out_valid (ov4),
    .out_code  (oc4)
`ifdef HT_OUT_LAST_EN
    ,
    .out_last  (ol4)
`endif
  );

  int total = 0;
  int bad   = 0;
  int mw [16];
  int ms [16];
  bit exp_bit  [$];
  bit exp_last [$];

  function automatic int cur_n();    return sel ? 4 : 8;  endfunction
  function automatic int cur_olen(); return sel ? 4 : 5;  endfunction
  function automatic int cur_wmax(); return sel ? 15 : 7; endfunction

  // Reference: repeatedly merge the two lightest live subtrees (key = weight,
  // then slot), prepending 1 to the lighter subtree's codes and 0 to the other's.
  function automatic void model();
    int n, olen, a, b, s;
    int sw [16];
    bit act [16];
    int owner [16];
    int cv [16];
    int cl [16];
    n = cur_n();
    olen = cur_olen();
    exp_bit.delete();
    exp_last.delete();
    for (int i = 0; i < n; i++) begin
      sw[i] = mw[i]; act[i] = 1'b1; owner[i] = i; cv[i] = 0; cl[i] = 0;
    end
    for (int m = 0; m < n - 1; m++) begin
      a = -1;
      for (int i = 0; i < n; i++)
        if (act[i] && (a < 0 || sw[i] * 32 + i < sw[a] * 32 + a)) a = i;
      b = -1;
      for (int i = 0; i < n; i++)
        if (act[i] && i != a && (b < 0 || sw[i] * 32 + i < sw[b] * 32 + b)) b = i;
      for (int i = 0; i < n; i++) begin
        if (owner[i] == a) begin
          cv[i] += (1 << cl[i]); cl[i]++; owner[i] = b;
        end else if (owner[i] == b) begin
          cl[i]++;
        end
      end
      sw[b] += sw[a];
      act[a] = 1'b0;
    end
    for (int jj = 0; jj < olen; jj++) begin
      s = ms[jj];
      for (int bb = cl[s] - 1; bb >= 0; bb--) begin
        exp_bit.push_back(bit'((cv[s] >> bb) & 1));
        exp_last.push_back(bb == 0);
      end
    end
  endfunction

  // Expected stream from a literal such as "10 01 110": spaces separate codes.
  function automatic void exp_from_str(input string s);
    exp_bit.delete();
    exp_last.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "0" || s[i] == "1") begin
        exp_bit.push_back(s[i] == "1");
        exp_last.push_back((i == s.len() - 1) || (s[i+1] == " "));
      end
    end
  endfunction

  task automatic do_load();
    for (int k = 0; k < cur_n(); k++) begin
      in_valid  = 1'b1;
      in_weight = 4'(mw[k]);
      in_sym    = (k < cur_olen()) ? 3'(ms[k]) : 3'($urandom_range(cur_n() - 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Called right after the last load edge. Checks latency, every streamed bit,
  // and the drop afterwards. rst_at >= 0 asserts reset while that bit is shown.
  task automatic run_stream(input string name, input bit noise, input int rst_at);
    int lat;
    int nbits;
    nbits = exp_bit.size();
    @(negedge clk);
    lat = 1;
    while (obs_valid !== 1'b1 && lat < 64) begin
      if (noise) begin
        in_valid  = 1'($urandom);
        in_weight = 4'($urandom);
        in_sym    = 3'($urandom_range(cur_n() - 1));
      end
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat - 1 != cur_n()) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat - 1, cur_n());
    end
    if (obs_valid !== 1'b1) begin
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < nbits; i++) begin
      total++;
      if (obs_valid !== 1'b1 || obs_code !== exp_bit[i]) begin
        bad++;
        $display("FAIL %s bit %0d: got valid=%b code=%b, want valid=1 code=%b",
                 name, i, obs_valid, obs_code, exp_bit[i]);
      end
`ifdef HT_OUT_LAST_EN
      total++;
      if (obs_last !== exp_last[i]) begin
        bad++;
        $display("FAIL %s last %0d: got %b, want %b", name, i, obs_last, exp_last[i]);
      end
`endif
      if (i == rst_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (obs_valid !== 1'b0 || obs_code !== 1'b0) begin
          bad++;
          $display("FAIL %s rst_abort: got valid=%b code=%b, want 0 0", name, obs_valid, obs_code);
        end
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          total++;
          if (obs_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s post_rst_quiet: got valid=%b, want 0", name, obs_valid);
          end
        end
        return;
      end
      if (noise) begin
        in_valid  = (i < nbits - 1) ? 1'($urandom) : 1'b0;
        in_weight = 4'($urandom);
        in_sym    = 3'($urandom_range(cur_n() - 1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (obs_valid !== 1'b0 || obs_code !== 1'b0) begin
      bad++;
      $display("FAIL %s tail: got valid=%b code=%b, want 0 0", name, obs_valid, obs_code);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (ov8 !== 1'b0 || oc8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8: got valid=%b code=%b, want 0 0", ov8, oc8);
    end
    total++;
    if (ov4 !== 1'b0 || oc4 !== 1'b0) begin
      bad++;
      $display("FAIL reset4: got valid=%b code=%b, want 0 0", ov4, oc4);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic setup_ramp();
    sel = 1'b0;
    for (int i = 0; i < 16; i++) mw[i] = (i < 8) ? i : 0;
    ms = '{6, 7, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_from_str("10 01 11111 000 110");
  endtask

  task automatic test_uniform();
    sel = 1'b0;
    for (int i = 0; i < 16; i++) mw[i] = 1;
    ms = '{0, 7, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_from_str("111 000 100 011 110");
    do_load();
    run_stream("uniform", 1'b0, -1);
  endtask

  task automatic test_ramp();
    setup_ramp();
    do_load();
    run_stream("ramp", 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    setup_ramp();
    do_load();
    run_stream("reset_mid", 1'b0, 2);
    setup_ramp();
    do_load();
    run_stream("after_reset", 1'b0, -1);
  endtask

  task automatic test_ignore_in_valid();
    setup_ramp();
    do_load();
    run_stream("ignore_in_valid", 1'b1, -1);
  endtask

  task automatic test_small();
    sel = 1'b1;
    for (int i = 0; i < 16; i++) mw[i] = 15;
    ms = '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_from_str("00 01 10 11");
    do_load();
    run_stream("small", 1'b0, -1);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 10; r++) begin
      sel = (r % 3 == 2);
      for (int i = 0; i < 16; i++) begin
        mw[i] = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(cur_wmax()));
        ms[i] = int'($urandom_range(cur_n() - 1));
      end
      if (r == 0) for (int i = 0; i < 16; i++) mw[i] = 0;
      model();
      do_load();
      run_stream(sel ? "random4" : "random8", r[0], -1);
    end
    sel = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_uniform();
    test_ramp();
    test_reset_mid();
    test_ignore_in_valid();
    test_small();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
